// File: rtl/vc_input_buffer.sv
// ---------------------------------------------------------------------------
// vc_input_buffer
//
// Router input buffer with one independent circular FIFO per virtual channel
// (VC). One write and one read may be accepted per cycle, to the same VC or to
// different VCs. A read is accepted only when the VC already holds data before
// the clock edge; there is no write-to-read bypass. The read flit appears on
// buf_data_o one cycle after the request, together with buf_valid_o and a
// one-cycle credit pulse for the VC it came from.
//
// Optional feature macro: VC_INBUF_ERR_EN
//   defined   -> sticky overflow/underflow flags on buf_err_o
//   undefined -> buf_err_o tied to 2'b00
//
// Ports
//   clk          in   1                 clock, all state on rising edge
//   reset        in   1                 asynchronous active-low reset
//   buf_data_i   in   DATA_WIDTH        write flit
//   buf_write_i  in   1                 write request
//   buf_wvc_i    in   VC_W              target VC of the write
//   buf_read_i   in   1                 read request
//   buf_rvc_i    in   VC_W              source VC of the read
//   buf_data_o   out  DATA_WIDTH        registered read flit
//   buf_valid_o  out  1                 buf_data_o valid this cycle
//   buf_empty_o  out  NUM_VC            per-VC empty flag
//   buf_full_o   out  NUM_VC            per-VC full flag
//   buf_credit_o out  NUM_VC            per-VC credit-return pulse
//   buf_count_o  out  NUM_VC*CNT_W      per-VC occupancy, VC v at [v*CNT_W +: CNT_W]
//   buf_err_o    out  2                 sticky errors: bit0 overflow, bit1 underflow
// ---------------------------------------------------------------------------
module vc_input_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 5,
    parameter int NUM_VC     = 2,
    localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     buf_data_i,
    input  logic                      buf_write_i,
    input  logic [VC_W-1:0]           buf_wvc_i,
    input  logic                      buf_read_i,
    input  logic [VC_W-1:0]           buf_rvc_i,
    output logic [DATA_WIDTH-1:0]     buf_data_o,
    output logic                      buf_valid_o,
    output logic [NUM_VC-1:0]         buf_empty_o,
    output logic [NUM_VC-1:0]         buf_full_o,
    output logic [NUM_VC-1:0]         buf_credit_o,
    output logic [NUM_VC*CNT_W-1:0]   buf_count_o,
    output logic [1:0]                buf_err_o
);

    // Storage is deliberately not reset; only pointers and counts are.
    logic [DATA_WIDTH-1:0] mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]      wr_ptr [NUM_VC];
    logic [PTR_W-1:0]      rd_ptr [NUM_VC];
    logic [CNT_W-1:0]      count  [NUM_VC];

    logic [NUM_VC-1:0]     wr_hit;
    logic [NUM_VC-1:0]     rd_hit;
    logic [DATA_WIDTH-1:0] rd_flit;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-VC accept decode. Matching the request VC against each index
    // means an out-of-range VC simply matches nothing and is dropped.
    // A write into a full VC is still taken when the same VC is read in
    // the same cycle, since the read frees the slot at the same edge.
    always_comb begin
        rd_hit  = '0;
        wr_hit  = '0;
        rd_flit = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            rd_hit[v] = buf_read_i && (buf_rvc_i == VC_W'(v)) && (count[v] != '0);
            if (rd_hit[v]) begin
                rd_flit = mem[v][rd_ptr[v]];
            end
        end
        for (int v = 0; v < NUM_VC; v++) begin
            wr_hit[v] = buf_write_i && (buf_wvc_i == VC_W'(v))
                        && ((count[v] != CNT_W'(DEPTH)) || rd_hit[v]);
        end
    end

    // Status flags and flattened occupancy straight from the registered counts.
    always_comb begin
        buf_empty_o = '0;
        buf_full_o  = '0;
        buf_count_o = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            buf_empty_o[v]                 = (count[v] == '0);
            buf_full_o[v]                  = (count[v] == CNT_W'(DEPTH));
            buf_count_o[v*CNT_W +: CNT_W]  = count[v];
        end
    end

    // Flit storage write.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_hit[v]) begin
                mem[v][wr_ptr[v]] <= buf_data_i;
            end
        end
    end

    // Pointer/count bookkeeping and registered read outputs. Reset drops
    // any read accepted in the previous cycle, so no valid pulse survives it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            buf_valid_o  <= 1'b0;
            buf_credit_o <= '0;
            buf_data_o   <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_hit[v]) begin
                    wr_ptr[v] <= next_ptr(wr_ptr[v]);
                end
                if (rd_hit[v]) begin
                    rd_ptr[v] <= next_ptr(rd_ptr[v]);
                end
                case ({wr_hit[v], rd_hit[v]})
                    2'b10:   count[v] <= count[v] + 1'b1;
                    2'b01:   count[v] <= count[v] - 1'b1;
                    default: count[v] <= count[v];
                endcase
            end
            buf_valid_o  <= |rd_hit;
            buf_credit_o <= rd_hit;
            if (|rd_hit) begin
                buf_data_o <= rd_flit;
            end
        end
    end

`ifdef VC_INBUF_ERR_EN
    logic overflow;
    logic underflow;

    // An in-range write that is not accepted can only have hit a full VC.
    // Any read that is not accepted was either empty or out of range.
    assign overflow  = buf_write_i && (int'(buf_wvc_i) < NUM_VC) && (wr_hit == '0);
    assign underflow = buf_read_i && (rd_hit == '0);

    // Sticky flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_err_o <= 2'b00;
        end else begin
            buf_err_o <= buf_err_o | {underflow, overflow};
        end
    end
`else
    assign buf_err_o = 2'b00;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_vc_input_buffer
//
// Directed self-checking bench for vc_input_buffer (DEPTH=5, NUM_VC=2,
// DATA_WIDTH=16). Per-VC reference queues decide which requests are accepted;
// accepted reads push their expected flit onto a scoreboard that is popped
// when the DUT presents the flit one cycle later. Honours VC_INBUF_ERR_EN for
// the expected error flags.
// ---------------------------------------------------------------------------
module tb_vc_input_buffer;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 5;
    localparam int NUM_VC     = 2;
    localparam int CNT_W      = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [DATA_WIDTH-1:0]   buf_data_i;
    logic                    buf_write_i;
    logic                    buf_wvc_i;
    logic                    buf_read_i;
    logic                    buf_rvc_i;
    logic [DATA_WIDTH-1:0]   buf_data_o;
    logic                    buf_valid_o;
    logic [NUM_VC-1:0]       buf_empty_o;
    logic [NUM_VC-1:0]       buf_full_o;
    logic [NUM_VC-1:0]       buf_credit_o;
    logic [NUM_VC*CNT_W-1:0] buf_count_o;
    logic [1:0]              buf_err_o;

    int checks   = 0;
    int failures = 0;

    // Reference FIFOs per VC and the read-data scoreboard.
    logic [15:0] mq0 [$];
    logic [15:0] mq1 [$];
    logic [15:0] sb  [$];

    logic        exp_valid;
    logic [1:0]  exp_credit;
    logic [1:0]  exp_err;
    logic [15:0] last_data;

    vc_input_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .NUM_VC     (NUM_VC)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .buf_data_i   (buf_data_i),
        .buf_write_i  (buf_write_i),
        .buf_wvc_i    (buf_wvc_i),
        .buf_read_i   (buf_read_i),
        .buf_rvc_i    (buf_rvc_i),
        .buf_data_o   (buf_data_o),
        .buf_valid_o  (buf_valid_o),
        .buf_empty_o  (buf_empty_o),
        .buf_full_o   (buf_full_o),
        .buf_credit_o (buf_credit_o),
        .buf_count_o  (buf_count_o),
        .buf_err_o    (buf_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the reference state after one edge.
    task automatic checkState(input string tag);
        logic [5:0] exp_cnt;
        logic [1:0] exp_empty;
        logic [1:0] exp_full;
        exp_cnt   = {CNT_W'(mq1.size()), CNT_W'(mq0.size())};
        exp_empty = {mq1.size() == 0, mq0.size() == 0};
        exp_full  = {mq1.size() == DEPTH, mq0.size() == DEPTH};
        checkOutput({tag, ".valid"}, 32'(buf_valid_o), 32'(exp_valid));
        if (exp_valid && sb.size() > 0) begin
            last_data = sb.pop_front();
        end
        checkOutput({tag, ".data"},   32'(buf_data_o),   32'(last_data));
        checkOutput({tag, ".credit"}, 32'(buf_credit_o), 32'(exp_credit));
        checkOutput({tag, ".count"},  32'(buf_count_o),  32'(exp_cnt));
        checkOutput({tag, ".empty"},  32'(buf_empty_o),  32'(exp_empty));
        checkOutput({tag, ".full"},   32'(buf_full_o),   32'(exp_full));
        checkOutput({tag, ".err"},    32'(buf_err_o),    32'(exp_err));
    endtask

    // Drive one cycle of requests, update the reference model, then check.
    task automatic applyStimulus(input logic wr, input logic wvc, input logic [15:0] wd,
                                 input logic rd, input logic rvc, input string tag);
        logic rd_ok;
        logic wr_ok;
        int   wsize;
        rd_ok = rd && ((rvc == 1'b0) ? (mq0.size() > 0) : (mq1.size() > 0));
        wsize = (wvc == 1'b0) ? mq0.size() : mq1.size();
        wr_ok = wr && ((wsize < DEPTH) || (rd_ok && (rvc == wvc)));
        exp_valid  = rd_ok;
        exp_credit = 2'b00;
        if (rd_ok) begin
            if (rvc == 1'b0) sb.push_back(mq0.pop_front());
            else             sb.push_back(mq1.pop_front());
            exp_credit[rvc] = 1'b1;
        end
        if (wr_ok) begin
            if (wvc == 1'b0) mq0.push_back(wd);
            else             mq1.push_back(wd);
        end
`ifdef VC_INBUF_ERR_EN
        if (wr && !wr_ok) exp_err[0] = 1'b1;
        if (rd && !rd_ok) exp_err[1] = 1'b1;
`endif
        buf_write_i = wr;
        buf_wvc_i   = wvc;
        buf_data_i  = wd;
        buf_read_i  = rd;
        buf_rvc_i   = rvc;
        @(posedge clk);
        #1;
        buf_write_i = 1'b0;
        buf_read_i  = 1'b0;
        checkState(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        buf_data_i  = '0;
        buf_write_i = 1'b0;
        buf_wvc_i   = 1'b0;
        buf_read_i  = 1'b0;
        buf_rvc_i   = 1'b0;
        exp_valid   = 1'b0;
        exp_credit  = 2'b00;
        exp_err     = 2'b00;
        last_data   = 16'h0000;

        // Reset state
        #1;
        checkState("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FIFO order on VC0, full after five writes, empty after five reads
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 16'(i), 1'b0, 1'b0, "fill0");
        checkOutput("full0_after5", 32'(buf_full_o[0]), 32'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "drain0");
        checkOutput("empty0_after5", 32'(buf_empty_o[0]), 32'd1);

        // Full VC0: write with concurrent read keeps count at 5
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 16'(i), 1'b0, 1'b0, "refill0");
        applyStimulus(1'b1, 1'b0, 16'h00AA, 1'b1, 1'b0, "full_wr_rd");
        checkOutput("full_wr_rd_cnt", 32'(buf_count_o[2:0]), 32'd5);
        checkOutput("full_wr_rd_data", 32'(buf_data_o), 32'h0001);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "drain_aa");
        checkOutput("aa_last", 32'(buf_data_o), 32'h00AA);

        // Twelve write/read pairs on VC1 wrap the pointers twice
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, "wrap_wr");
            checkOutput("wrap_cnt_le1", 32'(buf_count_o[5:3] <= 3'd1), 32'd1);
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, "wrap_rd");
        end

        // Write VC0 and read VC1 in the same cycle
        applyStimulus(1'b1, 1'b1, 16'h00BB, 1'b0, 1'b0, "pre_vc1");
        applyStimulus(1'b1, 1'b0, 16'h00CC, 1'b1, 1'b1, "cross");
        checkOutput("cross_credit", 32'(buf_credit_o), 32'h2);
        checkOutput("cross_data", 32'(buf_data_o), 32'h00BB);

        // Error flags: overflow on full VC0, underflow on empty VC1
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'(16'h0010 + i), 1'b0, 1'b0, "fill_err");
        applyStimulus(1'b1, 1'b0, 16'h00EE, 1'b0, 1'b0, "overflow");
`ifdef VC_INBUF_ERR_EN
        checkOutput("err_overflow", 32'(buf_err_o), 32'h1);
`else
        checkOutput("err_tied_ovf", 32'(buf_err_o), 32'h0);
`endif
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, "underflow");
`ifdef VC_INBUF_ERR_EN
        checkOutput("err_underflow", 32'(buf_err_o), 32'h3);
`else
        checkOutput("err_tied_udf", 32'(buf_err_o), 32'h0);
`endif
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, "err_hold");

        // Reset asserted mid-read
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "pre_reset_rd");
        buf_read_i = 1'b1;
        buf_rvc_i  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mq0.delete();
        mq1.delete();
        sb.delete();
        exp_valid  = 1'b0;
        exp_credit = 2'b00;
        exp_err    = 2'b00;
        last_data  = 16'h0000;
        checkState("reset_mid");
        checkOutput("reset_empty", 32'(buf_empty_o), 32'h3);
        @(posedge clk);
        #1;
        checkState("reset_hold");
        buf_read_i = 1'b0;
        rst_n      = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, "post_reset1");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, "post_reset2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 5, entries per virtual channel (VC), any integer >= 2.
REQ-003 SHALL have parameter NUM_VC, default 2, number of VCs, any integer >= 1.
REQ-004 SHALL derive VC_W = max(1, ceil(log2(NUM_VC))), PTR_W = max(1, ceil(log2(DEPTH))) and CNT_W = ceil(log2(DEPTH+1)) as localparams.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port buf_data_i, input, DATA_WIDTH, write flit.
REQ-008 SHALL have port buf_write_i, input, 1, write request.
REQ-009 SHALL have port buf_wvc_i, input, VC_W, target VC of the write.
REQ-010 SHALL have port buf_read_i, input, 1, read request.
REQ-011 SHALL have port buf_rvc_i, input, VC_W, source VC of the read.
REQ-012 SHALL have port buf_data_o, output, DATA_WIDTH, registered read flit.
REQ-013 SHALL have port buf_valid_o, output, 1, buf_data_o holds a valid flit this cycle.
REQ-014 SHALL have port buf_empty_o, output, NUM_VC, per-VC empty flag.
REQ-015 SHALL have port buf_full_o, output, NUM_VC, per-VC full flag.
REQ-016 SHALL have port buf_credit_o, output, NUM_VC, per-VC one-cycle credit-return pulse.
REQ-017 SHALL have port buf_count_o, output, NUM_VC*CNT_W, per-VC occupancy; VC v at bits [v*CNT_W +: CNT_W].
REQ-018 SHALL have port buf_err_o, output, 2, sticky error flags: bit0 overflow, bit1 underflow.

Function
REQ-019 SHALL keep an independent circular FIFO per VC, with write pointer, read pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-020 SHALL accept a write when buf_write_i=1, buf_wvc_i<NUM_VC and the VC is not full, or is full with an accepted same-cycle read on that VC.
REQ-021 SHALL accept a read when buf_read_i=1, buf_rvc_i<NUM_VC and the VC count is nonzero before the edge; there SHALL be no empty-FIFO write-to-read bypass.
REQ-022 SHALL present the accepted read's flit on buf_data_o with buf_valid_o=1 exactly one cycle after the request; otherwise buf_valid_o=0 and buf_data_o holds its last value.
REQ-023 SHALL pulse buf_credit_o[v] high in the same cycle as buf_valid_o for a read from VC v.
REQ-024 SHALL update count +1 on write only, -1 on read only, and leave it unchanged on simultaneous write and read on the same VC.
REQ-025 SHALL drive buf_empty_o[v]=(count==0) and buf_full_o[v]=(count==DEPTH) combinationally from registered count.
REQ-026 SHALL allow a write to VC a and a read from VC b≠a in the same cycle with no interaction.
REQ-027 SHALL silently drop rejected requests (full, empty, or out-of-range VC) with no state change other than REQ-033.

Reset
REQ-028 SHALL, when reset=0, asynchronously clear all pointers and counts, buf_valid_o, buf_credit_o, buf_data_o and buf_err_o to 0.
REQ-029 SHALL therefore hold buf_empty_o all-ones and buf_full_o all-zeros during and after reset.
REQ-030 SHALL discard in-flight reads on reset assertion; no buf_valid_o pulse follows reset deassertion.
REQ-031 SHALL leave storage array contents uninitialised; buf_data_o reflects storage only after a valid read.

Configuration
REQ-032 SHALL use macro VC_INBUF_ERR_EN to compile in error detection.
REQ-033 SHALL, with VC_INBUF_ERR_EN defined, set buf_err_o[0] on a write rejected for full and buf_err_o[1] on a read rejected for empty or out-of-range VC; both bits clear only by reset.
REQ-034 SHALL, without VC_INBUF_ERR_EN, tie buf_err_o to 2'b00 with no error logic.

Verification
REQ-035 SHALL cover: DEPTH=5, NUM_VC=2; write 0x0001..0x0005 to VC0, then read 5 times -> same order, valid one cycle after each read, full_o[0]=1 after fifth write, empty_o[0]=1 after fifth read.
REQ-036 SHALL cover: VC0 full; write 0x00AA with concurrent read -> count stays 5, 0x0001 output, 0x00AA read last.
REQ-037 SHALL cover: 12 write/read pairs on VC1 -> pointer wraps twice, data order preserved, count_o for VC1 never exceeds 1.
REQ-038 SHALL cover: write VC0 and read VC1 in same cycle -> independent counts; credit_o=2'b10 one cycle later.
REQ-039 SHALL cover: with VC_INBUF_ERR_EN, write to full VC0 -> err_o=2'b01; read empty VC1 -> err_o=2'b11; errors held until reset=0.
REQ-040 SHALL cover: reset=0 asserted mid-read -> valid_o=0 immediately, counts 0, empty_o=2'b11, no valid pulse after release.
